// File: rtl/data_mem_unit.sv
// data_mem_unit
//   Data-memory stage of the RISC-V core. It performs one load or store per
//   request against a DEPTH x 32-bit flop-array memory. Byte, half and word
//   sizing and sign/zero extension follow the RISC-V funct3 encoding.
//   Requests and responses use valid/ready handshakes, sequenced by a
//   three-state FSM (IDLE -> ACCESS -> RESP).
//
// Ports
//   Clock         in   rising-edge clock
//   Reset         in   asynchronous, active-high reset (also clears memory)
//   req_valid     in   request present
//   req_ready     out  request accepted when high (IDLE only)
//   req_we        in   1 = store, 0 = load
//   req_addr      in   word index
//   req_byte_off  in   byte offset within the word
//   req_funct3    in   RISC-V funct3 size/sign code
//   req_wdata     in   store data, LSB-aligned
//   rsp_valid     out  response present (RESP state)
//   rsp_ready     in   consumer accepts the response
//   rsp_rdata     out  extended load result; 0 for stores and errors
//   rsp_err       out  misaligned or unsupported request
module data_mem_unit #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_byte_off,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [1:0]        cap_off;
    logic [2:0]        cap_f3;
    logic [31:0]       cap_wdata;

    logic [31:0] mem [DEPTH];

    logic [31:0] word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        err;
    logic [31:0] load_val;
    logic [3:0]  byte_en;
    logic [31:0] wr_data;

    // FSM state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = ACCESS;
            end
            ACCESS: begin
                next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request capture
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_off   <= '0;
            cap_f3    <= '0;
            cap_wdata <= '0;
        end else if (state == IDLE && req_valid) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_off   <= req_byte_off;
            cap_f3    <= req_funct3;
            cap_wdata <= req_wdata;
        end
    end

    // Decode of the captured request: error detection, load extraction,
    // and store lane enables. Store data is replicated across lanes so the
    // byte enables alone pick the destination.
    always_comb begin
        word     = mem[cap_addr];
        err      = 1'b0;
        load_val = '0;
        byte_en  = '0;
        wr_data  = cap_wdata;

        case (cap_off)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        sel_half = cap_off[1] ? word[31:16] : word[15:0];

        if (cap_we) begin
            case (cap_f3)
                3'b000: begin
                    wr_data = {4{cap_wdata[7:0]}};
                    case (cap_off)
                        2'd0:    byte_en = 4'b0001;
                        2'd1:    byte_en = 4'b0010;
                        2'd2:    byte_en = 4'b0100;
                        default: byte_en = 4'b1000;
                    endcase
                end
                3'b001: begin
                    wr_data = {2{cap_wdata[15:0]}};
                    if (cap_off[0]) err = 1'b1;
                    else            byte_en = cap_off[1] ? 4'b1100 : 4'b0011;
                end
                3'b010: begin
                    if (cap_off != 2'd0) err = 1'b1;
                    else                 byte_en = 4'b1111;
                end
                default: err = 1'b1;
            endcase
        end else begin
            case (cap_f3)
                3'b000: load_val = {{24{sel_byte[7]}}, sel_byte};
                3'b001: begin
                    if (cap_off[0]) err = 1'b1;
                    else            load_val = {{16{sel_half[15]}}, sel_half};
                end
                3'b010: begin
                    if (cap_off != 2'd0) err = 1'b1;
                    else                 load_val = word;
                end
                3'b100: load_val = {24'h0, sel_byte};
                3'b101: begin
                    if (cap_off[0]) err = 1'b1;
                    else            load_val = {16'h0, sel_half};
                end
                default: err = 1'b1;
            endcase
        end
    end

    // Memory array: cleared by Reset, written at the ACCESS edge of a
    // valid store
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i[ADDR_W-1:0]] <= '0;
            end
        end else if (state == ACCESS && cap_we && !err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[cap_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    // Response registers, loaded at the ACCESS edge and held through RESP
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == ACCESS) begin
            rsp_rdata <= (cap_we || err) ? 32'h0 : load_val;
            rsp_err   <= err;
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit
//   Directed testbench for data_mem_unit. Each feature has its own task with
//   hand-computed expected values.
module tb_data_mem_unit;

    logic        Clock;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [4:0]  req_addr;
    logic [1:0]  req_byte_off;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    data_mem_unit #(
        .ADDR_W(5),
        .DEPTH (32)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_byte_off(req_byte_off),
        .req_funct3  (req_funct3),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // One full transaction. Called 1 time unit after a rising edge.
    task automatic xfer(input logic we, input logic [4:0] a, input logic [1:0] off,
                        input logic [2:0] f3, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
        int unsigned n = 0;
        req_we       = we;
        req_addr     = a;
        req_byte_off = off;
        req_funct3   = f3;
        req_wdata    = wd;
        req_valid    = 1'b1;
        while (req_ready !== 1'b1 && n < 10) begin
            @(posedge Clock); #1;
            n++;
        end
        if (n >= 10) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: req_ready=%b required 1", req_ready);
        end
        @(posedge Clock); #1;
        req_valid = 1'b0;
        @(posedge Clock); #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_valid_latency: rsp_valid=%b required 1", rsp_valid);
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (rsp_ready === 1'b1) begin
            @(posedge Clock); #1;
            checks++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL return_idle: req_ready=%b rsp_valid=%b required 1 0",
                         req_ready, rsp_valid);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        er;
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b rdata=%h err=%b required 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        Reset = 1'b0;
        @(posedge Clock); #1;
        xfer(1'b0, 5'd0, 2'd0, 3'b010, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL lw_addr0: rdata=%h err=%b required 00000000 0", rd, er);
        end
    endtask

    task automatic test_sizing();
        logic [31:0] rd;
        logic        er;
        xfer(1'b1, 5'd3, 2'd0, 3'b010, 32'h8899AABB, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL sw_rsp: rdata=%h err=%b required 00000000 0", rd, er);
        end
        xfer(1'b0, 5'd3, 2'd0, 3'b000, 32'h0, rd, er);
        checks++;
        if (rd !== 32'hFFFFFFBB || er !== 1'b0) begin
            errors++;
            $display("FAIL lb_off0: rdata=%h err=%b required ffffffbb 0", rd, er);
        end
        xfer(1'b0, 5'd3, 2'd3, 3'b100, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h00000088 || er !== 1'b0) begin
            errors++;
            $display("FAIL lbu_off3: rdata=%h err=%b required 00000088 0", rd, er);
        end
        xfer(1'b0, 5'd3, 2'd2, 3'b001, 32'h0, rd, er);
        checks++;
        if (rd !== 32'hFFFF8899 || er !== 1'b0) begin
            errors++;
            $display("FAIL lh_off2: rdata=%h err=%b required ffff8899 0", rd, er);
        end
        xfer(1'b0, 5'd3, 2'd2, 3'b101, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h00008899 || er !== 1'b0) begin
            errors++;
            $display("FAIL lhu_off2: rdata=%h err=%b required 00008899 0", rd, er);
        end
        xfer(1'b0, 5'd3, 2'd1, 3'b000, 32'h0, rd, er);
        checks++;
        if (rd !== 32'hFFFFFFAA || er !== 1'b0) begin
            errors++;
            $display("FAIL lb_off1: rdata=%h err=%b required ffffffaa 0", rd, er);
        end
        xfer(1'b0, 5'd3, 2'd0, 3'b001, 32'h0, rd, er);
        checks++;
        if (rd !== 32'hFFFFAABB || er !== 1'b0) begin
            errors++;
            $display("FAIL lh_off0: rdata=%h err=%b required ffffaabb 0", rd, er);
        end
        xfer(1'b0, 5'd3, 2'd0, 3'b010, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h8899AABB || er !== 1'b0) begin
            errors++;
            $display("FAIL lw_addr3: rdata=%h err=%b required 8899aabb 0", rd, er);
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd;
        logic        er;
        xfer(1'b1, 5'd7, 2'd0, 3'b010, 32'h11223344, rd, er);
        xfer(1'b1, 5'd7, 2'd1, 3'b000, 32'h000000EE, rd, er);
        xfer(1'b0, 5'd7, 2'd0, 3'b010, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h1122EE44 || er !== 1'b0) begin
            errors++;
            $display("FAIL sb_merge: rdata=%h err=%b required 1122ee44 0", rd, er);
        end
        xfer(1'b1, 5'd7, 2'd2, 3'b001, 32'h0000CAFE, rd, er);
        xfer(1'b0, 5'd7, 2'd0, 3'b010, 32'h0, rd, er);
        checks++;
        if (rd !== 32'hCAFEEE44 || er !== 1'b0) begin
            errors++;
            $display("FAIL sh_merge: rdata=%h err=%b required cafeee44 0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        xfer(1'b1, 5'd5, 2'd2, 3'b010, 32'h12345678, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            errors++;
            $display("FAIL sw_misaligned: rdata=%h err=%b required 00000000 1", rd, er);
        end
        xfer(1'b0, 5'd5, 2'd0, 3'b010, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL mem_unchanged: rdata=%h err=%b required 00000000 0", rd, er);
        end
        xfer(1'b0, 5'd3, 2'd1, 3'b001, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            errors++;
            $display("FAIL lh_misaligned: rdata=%h err=%b required 00000000 1", rd, er);
        end
        xfer(1'b0, 5'd3, 2'd0, 3'b011, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            errors++;
            $display("FAIL load_f3_011: rdata=%h err=%b required 00000000 1", rd, er);
        end
        xfer(1'b1, 5'd5, 2'd0, 3'b100, 32'hFFFFFFFF, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            errors++;
            $display("FAIL store_f3_100: rdata=%h err=%b required 00000000 1", rd, er);
        end
        xfer(1'b0, 5'd5, 2'd0, 3'b010, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL mem_unchanged2: rdata=%h err=%b required 00000000 0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        int unsigned n = 0;
        rsp_ready    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 5'd3;
        req_byte_off = 2'd0;
        req_funct3   = 3'b010;
        req_wdata    = 32'h0;
        req_valid    = 1'b1;
        while (req_ready !== 1'b1 && n < 10) begin
            @(posedge Clock); #1;
            n++;
        end
        @(posedge Clock); #1;
        // Competing request held high while the response is stalled
        req_addr = 5'd7;
        @(posedge Clock); #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8899AABB || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: vld=%b rdata=%h err=%b rdy=%b required 1 8899aabb 0 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
            @(posedge Clock); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge Clock); #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: rdy=%b vld=%b required 1 0", req_ready, rsp_valid);
        end
        @(posedge Clock); #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_stale_accept: rdy=%b vld=%b required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd;
        logic        er;
        req_we       = 1'b1;
        req_addr     = 5'd2;
        req_byte_off = 2'd0;
        req_funct3   = 3'b010;
        req_wdata    = 32'hDEADBEEF;
        req_valid    = 1'b1;
        @(posedge Clock); #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_access: req_ready=%b required 0", req_ready);
        end
        #1;
        Reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: rdy=%b vld=%b rdata=%h err=%b required 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(posedge Clock); #3;
        Reset = 1'b0;
        @(posedge Clock); #1;
        xfer(1'b0, 5'd2, 2'd0, 3'b010, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL lost_store: rdata=%h err=%b required 00000000 0", rd, er);
        end
        xfer(1'b0, 5'd3, 2'd0, 3'b010, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL mem_cleared: rdata=%h err=%b required 00000000 0", rd, er);
        end
    endtask

    initial begin
        Reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_byte_off = '0;
        req_funct3   = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;
        #2;
        test_reset();
        test_sizing();
        test_partial_store();
        test_errors();
        test_backpressure();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
